// File: rtl/chacha_pkg.sv
// Shared ChaCha20 constants, state type, FSM encoding and helpers.
package chacha_pkg;

  localparam logic [3:0][31:0] Sigma = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  typedef logic [15:0][31:0] state_t;

  typedef enum logic [1:0] {StIdle, StReady, StRound, StOut} fsm_e;

  function automatic bit rounds_legal(int unsigned r);
    return (r == 8) || (r == 12) || (r == 20);
  endfunction

  function automatic state_t init_state(logic [255:0] key, logic [95:0] nonce, logic [31:0] ctr);
    state_t s;
    for (int i = 0; i < 4; i++) s[i] = Sigma[i];
    for (int i = 0; i < 8; i++) s[4+i] = key[32*i +: 32];
    s[12] = ctr;
    for (int i = 0; i < 3; i++) s[13+i] = nonce[32*i +: 32];
    return s;
  endfunction

endpackage

// File: rtl/chacha20_stream_core_if.sv
// Key load and block-stream handshake bundle of the ChaCha20 stream core.
interface chacha20_stream_core_if;
  logic         init;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  ctr_init;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_data;
  logic [63:0]  in_keep;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_data;
  logic [63:0]  out_keep;
  logic         out_last;
  logic         busy;
  logic         ctr_err;

  modport slave (
    input  init, key, nonce, ctr_init, in_valid, in_data, in_keep, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last, busy, ctr_err
  );

  modport master (
    output init, key, nonce, ctr_init, in_valid, in_data, in_keep, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last, busy, ctr_err
  );
endinterface

// File: rtl/chacha20_qr.sv
// Combinational ChaCha quarter-round (rotates 16/12/8/7).
module chacha20_qr (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);
  logic [31:0] a1, b1, c1, d1, d1x, b1x, d2x, b2x;

  always_comb begin
    a1  = a_i + b_i;
    d1x = d_i ^ a1;
    d1  = {d1x[15:0], d1x[31:16]};
    c1  = c_i + d1;
    b1x = b_i ^ c1;
    b1  = {b1x[19:0], b1x[31:20]};
    a_o = a1 + b1;
    d2x = d1 ^ a_o;
    d_o = {d2x[23:0], d2x[31:24]};
    c_o = c1 + d_o;
    b2x = b1 ^ c_o;
    b_o = {b2x[24:0], b2x[31:25]};
  end
endmodule

// File: rtl/chacha20_stream_core.sv
// ChaCha20 stream core: one 64-byte block in flight, one round per cycle.
module chacha20_stream_core import chacha_pkg::*; #(
  parameter int unsigned ROUNDS = 20
) (
  input logic                    clk,
  input logic                    reset_n,
  chacha20_stream_core_if.slave  bus
);

  if (!rounds_legal(ROUNDS)) begin : g_bad_rounds
    $fatal(1, "chacha20_stream_core: ROUNDS must be 8, 12 or 20");
  end

  fsm_e         st_q, st_d;
  logic [255:0] key_q, key_d;
  logic [95:0]  nonce_q, nonce_d;
  logic [31:0]  ctr_q, ctr_d, ctr0_q, ctr0_d, ctr_inc;
  logic         err_q, err_d;
  state_t       work_q, work_d, round_st, init_st, ks;
  logic [511:0] data_q, data_d, ks_x;
  logic [63:0]  keep_q, keep_d;
  logic         last_q, last_d;
  logic [4:0]   rnd_q, rnd_d;
  logic         in_rdy, hs, init_ok, diag;

  logic [3:0]  idx_b [4];
  logic [3:0]  idx_c [4];
  logic [3:0]  idx_d [4];
  logic [31:0] qa [4];
  logic [31:0] qb [4];
  logic [31:0] qc [4];
  logic [31:0] qd [4];

  // Round 1 (rnd_q == 0) is a column round; diagonals rotate the b/c/d rows by 1/2/3.
  assign diag = rnd_q[0];

  for (genvar g = 0; g < 4; g++) begin : g_qr
    logic [1:0] sb, sc, sd;
    assign sb = 2'(g) + {1'b0, diag};
    assign sc = 2'(g) + {diag, 1'b0};
    assign sd = 2'(g) + {diag, diag};
    assign idx_b[g] = {2'b01, sb};
    assign idx_c[g] = {2'b10, sc};
    assign idx_d[g] = {2'b11, sd};

    chacha20_qr u_qr (
      .a_i (work_q[g]),
      .b_i (work_q[idx_b[g]]),
      .c_i (work_q[idx_c[g]]),
      .d_i (work_q[idx_d[g]]),
      .a_o (qa[g]),
      .b_o (qb[g]),
      .c_o (qc[g]),
      .d_o (qd[g])
    );
  end

  always_comb begin
    round_st = work_q;
    for (int g = 0; g < 4; g++) begin
      round_st[g]        = qa[g];
      round_st[idx_b[g]] = qb[g];
      round_st[idx_c[g]] = qc[g];
      round_st[idx_d[g]] = qd[g];
    end
  end

  // Key, nonce and counter are stable for the whole block, so the input state is rebuilt.
  assign init_st = init_state(key_q, nonce_q, ctr_q);

  always_comb begin
    for (int w = 0; w < 16; w++) ks[w] = work_q[w] + init_st[w];
    ks_x = ks ^ data_q;
    for (int b = 0; b < 64; b++) begin
      if (!keep_q[b]) ks_x[8*b +: 8] = 8'h00;
    end
  end

  assign in_rdy  = (st_q == StReady) && !err_q;
  assign hs      = bus.in_valid && in_rdy;
  assign init_ok = bus.init && ((st_q == StIdle) || (st_q == StReady));
  assign ctr_inc = ctr_q + 32'd1;

  always_comb begin
    st_d    = st_q;
    key_d   = key_q;
    nonce_d = nonce_q;
    ctr_d   = ctr_q;
    ctr0_d  = ctr0_q;
    err_d   = err_q;
    work_d  = work_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    rnd_d   = rnd_q;
    if (init_ok) begin
      key_d   = bus.key;
      nonce_d = bus.nonce;
      ctr_d   = bus.ctr_init;
      ctr0_d  = bus.ctr_init;
      err_d   = 1'b0;
      st_d    = StReady;
    end
    case (st_q)
      StReady: begin
        if (hs) begin
          work_d = init_state(key_d, nonce_d, ctr_d);
          data_d = bus.in_data;
          keep_d = bus.in_keep;
          last_d = bus.in_last;
          rnd_d  = 5'd0;
          st_d   = StRound;
        end
      end
      StRound: begin
        if (rnd_q == 5'(ROUNDS)) begin
          data_d = ks_x;
          st_d   = StOut;
        end else begin
          work_d = round_st;
          rnd_d  = rnd_q + 5'd1;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          ctr_d = ctr_inc;
          if (ctr_inc == ctr0_q) err_d = 1'b1;
          st_d = last_q ? StIdle : StReady;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q    <= StIdle;
      key_q   <= '0;
      nonce_q <= '0;
      ctr_q   <= '0;
      ctr0_q  <= '0;
      err_q   <= 1'b0;
      work_q  <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      rnd_q   <= '0;
    end else begin
      st_q    <= st_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      ctr_q   <= ctr_d;
      ctr0_q  <= ctr0_d;
      err_q   <= err_d;
      work_q  <= work_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      rnd_q   <= rnd_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (st_q == StOut);
  assign bus.out_data  = data_q;
  assign bus.out_keep  = keep_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (st_q == StRound) || (st_q == StOut);
  assign bus.ctr_err   = err_q;

endmodule

// File: tb/tb_chacha20_stream_core.sv
// Scoreboard bench for chacha20_stream_core against an independent ChaCha block model.
module tb_chacha20_stream_core;

  logic clk;
  logic reset_n;

  chacha20_stream_core_if bus20 ();
  chacha20_stream_core_if bus8 ();
  chacha20_stream_core_if bus12 ();

  chacha20_stream_core #(.ROUNDS(20)) dut20 (.clk(clk), .reset_n(reset_n), .bus(bus20));
  chacha20_stream_core #(.ROUNDS(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(bus8));
  chacha20_stream_core #(.ROUNDS(12)) dut12 (.clk(clk), .reset_n(reset_n), .bus(bus12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [255:0] m_key;
  logic [95:0]  m_nonce;
  logic [31:0]  m_ctr;
  logic [255:0] rfc_key;
  localparam logic [95:0] Nonce232 = 96'h00000000_4a000000_09000000;
  localparam logic [95:0] Nonce242 = 96'h00000000_4a000000_00000000;

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [511:0] ks_model(input logic [255:0] k, input logic [95:0] n,
                                            input logic [31:0] c, input int rounds);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [511:0] r;
    int qa [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int qb [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
    int qc [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
    int qd [8] = '{12, 13, 14, 15, 15, 12, 13, 14};
    int a, b, cc, d, j;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    x = s;
    for (int rd = 0; rd < rounds; rd++) begin
      for (int q = 0; q < 4; q++) begin
        j = (rd % 2) * 4 + q;
        a = qa[j]; b = qb[j]; cc = qc[j]; d = qd[j];
        x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 16);
        x[cc] = x[cc] + x[d]; x[b] = rl(x[b] ^ x[cc], 12);
        x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 8);
        x[cc] = x[cc] + x[d]; x[b] = rl(x[b] ^ x[cc], 7);
      end
    end
    for (int w = 0; w < 16; w++) r[32*w +: 32] = x[w] + s[w];
    return r;
  endfunction

  function automatic logic [511:0] mask(input logic [511:0] v, input logic [63:0] k);
    logic [511:0] r = v;
    for (int b = 0; b < 64; b++) if (!k[b]) r[8*b +: 8] = 8'h00;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    bus20.init = 1'b1; bus20.key = k; bus20.nonce = n; bus20.ctr_init = c;
    m_key = k; m_nonce = n; m_ctr = c;
    tick();
    bus20.init = 1'b0;
  endtask

  task automatic send(input logic [511:0] d, input logic [63:0] k, input logic l);
    exp_t e;
    int n = 0;
    while (bus20.in_ready !== 1'b1 && n < 50) begin tick(); n++; end
    if (bus20.in_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL send_ready: in_ready=%b required 1", bus20.in_ready);
      return;
    end
    bus20.in_valid = 1'b1; bus20.in_data = d; bus20.in_keep = k; bus20.in_last = l;
    e.d = mask(ks_model(m_key, m_nonce, m_ctr, 20) ^ d, k);
    e.k = k;
    e.l = l;
    sb.push_back(e);
    m_ctr = m_ctr + 32'd1;
    tick();
    bus20.in_valid = 1'b0;
  endtask

  task automatic recv(input string name, output logic [511:0] got);
    exp_t e;
    int n = 0;
    got = '0;
    bus20.out_ready = 1'b1;
    while (bus20.out_valid !== 1'b1 && n < 100) begin tick(); n++; end
    n_cmp++;
    if (bus20.out_valid !== 1'b1 || sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s_valid: out_valid=%b queued=%0d required 1", name, bus20.out_valid,
               sb.size());
      bus20.out_ready = 1'b0;
      return;
    end
    e = sb.pop_front();
    got = bus20.out_data;
    if (bus20.out_data !== e.d) begin
      n_bad++;
      $display("FAIL %s_data: got %h required %h", name, bus20.out_data, e.d);
    end
    n_cmp++;
    if (bus20.out_keep !== e.k) begin
      n_bad++;
      $display("FAIL %s_keep: got %h required %h", name, bus20.out_keep, e.k);
    end
    n_cmp++;
    if (bus20.out_last !== e.l) begin
      n_bad++;
      $display("FAIL %s_last: got %b required %b", name, bus20.out_last, e.l);
    end
    tick();
    bus20.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({bus20.in_ready, bus20.out_valid, bus20.busy, bus20.ctr_err, bus20.out_last} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b required 00000", {bus20.in_ready, bus20.out_valid,
               bus20.busy, bus20.ctr_err, bus20.out_last});
    end
    n_cmp++;
    if (bus20.out_data !== '0 || bus20.out_keep !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h/%h required 0", bus20.out_data, bus20.out_keep);
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (bus20.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_noinit_ready: got %b required 0", bus20.in_ready);
    end
  endtask

  task automatic test_rfc_block();
    logic [511:0] got;
    do_init(rfc_key, Nonce232, 32'd1);
    send('0, '1, 1'b1);
    recv("rfc232", got);
    n_cmp++;
    if (got[63:0] !== 64'h15593bd1e4e7f110) begin
      n_bad++;
      $display("FAIL rfc232_bytes: got %h required 15593bd1e4e7f110", got[63:0]);
    end
    n_cmp++;
    if (bus20.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rfc232_idle: in_ready=%b required 0", bus20.in_ready);
    end
  endtask

  task automatic test_rfc_encrypt();
    string pt;
    logic [511:0] b1, b2, got;
    logic [63:0] k2;
    pt = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
    b1 = '0; b2 = '0; k2 = '0;
    for (int i = 0; i < pt.len(); i++) begin
      if (i < 64) b1[8*i +: 8] = pt[i];
      else begin b2[8*(i-64) +: 8] = pt[i]; k2[i-64] = 1'b1; end
    end
    do_init(rfc_key, Nonce242, 32'd1);
    send(b1, '1, 1'b0);
    recv("rfc242_b1", got);
    n_cmp++;
    if (got[63:0] !== 64'h80f968259a352e6e) begin
      n_bad++;
      $display("FAIL rfc242_bytes: got %h required 80f968259a352e6e", got[63:0]);
    end
    send(b2, k2, 1'b1);
    recv("rfc242_b2", got);
    n_cmp++;
    if (bus20.in_ready !== 1'b0 || bus20.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rfc242_idle: in_ready=%b busy=%b required 0 0", bus20.in_ready, bus20.busy);
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] got;
    int n = 0;
    do_init({8{32'h0badf00d}}, 96'h1234_5678_9abc_def0_1122_3344, 32'd77);
    send({16{32'ha5a55a5a}}, 64'h00ff_ff00_f0f0_0f0f, 1'b0);
    while (bus20.out_valid !== 1'b1 && n < 100) begin tick(); n++; end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (bus20.out_valid !== 1'b1 || sb.size() == 0 || bus20.out_data !== sb[0].d ||
          bus20.out_keep !== sb[0].k || bus20.in_ready !== 1'b0 || bus20.busy !== 1'b1) begin
        n_bad++;
        $display("FAIL hold_%0d: valid=%b in_ready=%b busy=%b data=%h", c, bus20.out_valid,
                 bus20.in_ready, bus20.busy, bus20.out_data[63:0]);
      end
      tick();
    end
    recv("hold", got);
    n_cmp++;
    if (bus20.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_ready: in_ready=%b required 1", bus20.in_ready);
    end
  endtask

  task automatic test_keep_zero_and_init();
    logic [511:0] got;
    exp_t e;
    send({16{32'hdeadbeef}}, 64'h0, 1'b0);
    recv("keep0", got);
    send({16{32'h13579bdf}}, '1, 1'b0);
    recv("keep0_next", got);
    // Same-cycle init and handshake: the block must use the new key material.
    bus20.init = 1'b1; bus20.key = {8{32'hfeedface}}; bus20.nonce = 96'h5; bus20.ctr_init = 32'd9;
    bus20.in_valid = 1'b1; bus20.in_data = {16{32'h0f0f0f0f}}; bus20.in_keep = '1;
    bus20.in_last = 1'b1;
    m_key = bus20.key; m_nonce = bus20.nonce; m_ctr = 32'd9;
    e.d = ks_model(m_key, m_nonce, m_ctr, 20) ^ {16{32'h0f0f0f0f}};
    e.k = '1; e.l = 1'b1;
    sb.push_back(e);
    m_ctr = m_ctr + 32'd1;
    tick();
    bus20.init = 1'b0; bus20.in_valid = 1'b0;
    recv("init_hs", got);
  endtask

  task automatic test_ctr_wrap();
    logic [511:0] got;
    do_init(rfc_key, Nonce242, 32'hffffffff);
    send({16{32'h11111111}}, '1, 1'b0);
    recv("wrap_b1", got);
    send({16{32'h22222222}}, '1, 1'b1);
    recv("wrap_b2", got);
    do_init(rfc_key, Nonce242, 32'd5);
    force dut20.ctr_q = 32'd4;
    tick();
    release dut20.ctr_q;
    m_ctr = 32'd4;
    send({16{32'h33333333}}, '1, 1'b0);
    recv("wrap_b3", got);
    n_cmp++;
    if (bus20.ctr_err !== 1'b1 || bus20.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_err: ctr_err=%b in_ready=%b required 1 0", bus20.ctr_err,
               bus20.in_ready);
    end
    do_init(rfc_key, Nonce242, 32'd5);
    n_cmp++;
    if (bus20.ctr_err !== 1'b0 || bus20.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_clear: ctr_err=%b in_ready=%b required 0 1", bus20.ctr_err,
               bus20.in_ready);
    end
  endtask

  task automatic test_reset_mid_round();
    int seen = 0;
    send({16{32'h44444444}}, '1, 1'b0);
    tick(); tick(); tick();
    reset_n = 1'b0;
    tick();
    n_cmp++;
    if ({bus20.in_ready, bus20.out_valid, bus20.busy, bus20.ctr_err} !== 4'b0 ||
        bus20.out_data !== '0 || bus20.out_keep !== '0 || bus20.out_last !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_outs: flags=%b data=%h required 0", {bus20.in_ready,
               bus20.out_valid, bus20.busy, bus20.ctr_err}, bus20.out_data[63:0]);
    end
    reset_n = 1'b1;
    sb.delete();
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus20.out_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL midreset_novalid: out_valid cycles=%0d required 0", seen);
    end
    bus20.in_valid = 1'b1;
    tick();
    n_cmp++;
    if (bus20.in_ready !== 1'b0 || bus20.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_refuse: in_ready=%b busy=%b required 0 0", bus20.in_ready,
               bus20.busy);
    end
    bus20.in_valid = 1'b0;
  endtask

  task automatic test_rounds_latency();
    int lat8 = 0, lat12 = 0, lat20 = 0;
    logic [511:0] got8, got12, got20, pt;
    pt = {16{32'hc0ffee00}};
    bus8.init = 1'b1; bus12.init = 1'b1; bus20.init = 1'b1;
    bus8.key = rfc_key; bus12.key = rfc_key; bus20.key = rfc_key;
    bus8.nonce = Nonce232; bus12.nonce = Nonce232; bus20.nonce = Nonce232;
    bus8.ctr_init = 32'd1; bus12.ctr_init = 32'd1; bus20.ctr_init = 32'd1;
    tick();
    bus8.init = 1'b0; bus12.init = 1'b0; bus20.init = 1'b0;
    bus8.in_valid = 1'b1; bus12.in_valid = 1'b1; bus20.in_valid = 1'b1;
    bus8.in_data = pt; bus12.in_data = pt; bus20.in_data = pt;
    bus8.in_keep = '1; bus12.in_keep = '1; bus20.in_keep = '1;
    bus8.in_last = 1'b1; bus12.in_last = 1'b1; bus20.in_last = 1'b1;
    tick();
    bus8.in_valid = 1'b0; bus12.in_valid = 1'b0; bus20.in_valid = 1'b0;
    got8 = '0; got12 = '0; got20 = '0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (bus8.out_valid === 1'b1 && lat8 == 0) begin lat8 = n; got8 = bus8.out_data; end
      if (bus12.out_valid === 1'b1 && lat12 == 0) begin lat12 = n; got12 = bus12.out_data; end
      if (bus20.out_valid === 1'b1 && lat20 == 0) begin lat20 = n; got20 = bus20.out_data; end
    end
    n_cmp++;
    if (lat8 != 9) begin n_bad++; $display("FAIL lat_r8: got %0d required 9", lat8); end
    n_cmp++;
    if (lat12 != 13) begin n_bad++; $display("FAIL lat_r12: got %0d required 13", lat12); end
    n_cmp++;
    if (lat20 != 21) begin n_bad++; $display("FAIL lat_r20: got %0d required 21", lat20); end
    n_cmp++;
    if (got8 !== (ks_model(rfc_key, Nonce232, 32'd1, 8) ^ pt)) begin
      n_bad++;
      $display("FAIL data_r8: got %h", got8);
    end
    n_cmp++;
    if (got12 !== (ks_model(rfc_key, Nonce232, 32'd1, 12) ^ pt)) begin
      n_bad++;
      $display("FAIL data_r12: got %h", got12);
    end
    n_cmp++;
    if (got20 !== (ks_model(rfc_key, Nonce232, 32'd1, 20) ^ pt)) begin
      n_bad++;
      $display("FAIL data_r20: got %h", got20);
    end
    bus8.out_ready = 1'b1; bus12.out_ready = 1'b1; bus20.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0; bus12.out_ready = 1'b0; bus20.out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
    reset_n = 1'b0;
    bus20.init = 1'b0; bus20.key = '0; bus20.nonce = '0; bus20.ctr_init = '0;
    bus20.in_valid = 1'b0; bus20.in_data = '0; bus20.in_keep = '0; bus20.in_last = 1'b0;
    bus20.out_ready = 1'b0;
    bus8.init = 1'b0; bus8.key = '0; bus8.nonce = '0; bus8.ctr_init = '0;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_keep = '0; bus8.in_last = 1'b0;
    bus8.out_ready = 1'b0;
    bus12.init = 1'b0; bus12.key = '0; bus12.nonce = '0; bus12.ctr_init = '0;
    bus12.in_valid = 1'b0; bus12.in_data = '0; bus12.in_keep = '0; bus12.in_last = 1'b0;
    bus12.out_ready = 1'b0;
    m_key = '0; m_nonce = '0; m_ctr = '0;

    test_reset();
    test_rfc_block();
    test_rfc_encrypt();
    test_backpressure();
    test_keep_zero_and_init();
    test_ctr_wrap();
    test_reset_mid_round();
    test_rounds_latency();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
